timer_cmd_tx: RTL and testbench

Host-side command transmitter for the serial delay-timer interface. Accepts a delay value over a valid/ready handshake. Serializes it on the timer's single-bit data line as the start header `1101` followed by the delay bits, MSB first. It then waits for the timer's `done`, returns a one-cycle `ack`, and becomes ready for the next command; an optional watchdog aborts a command whose `done` never arrives.

---
 rtl/timer_cmd_tx.sv | 153 +++++++++++++++
 tb/tb_timer_cmd_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_cmd_tx.sv
// timer_cmd_tx
// Host-side command transmitter for the serial delay-timer interface.
// A delay value accepted over cmd_valid/cmd_ready is sent on ser_data as the
// 4-bit start header followed by the delay bits, MSB first. The block then
// waits for the timer's done and returns a one-cycle ack. An optional
// watchdog (TIMEOUT != 0) aborts a command whose done never arrives.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   cmd_valid    host presents a command
//   cmd_delay    delay value, sampled on the handshake cycle only
//   cmd_ready    block can accept a command (combinational from state)
//   ser_data     registered serial line to the timer, idles at 0
//   done         timer reports its count has expired
//   ack          registered one-cycle acknowledge to the timer
//   busy         command in progress
//   timeout_err  registered one-cycle pulse when the watchdog aborts
module timer_cmd_tx #(
  parameter logic [3:0]  HDR     = 4'b1101,
  parameter int          DLY_W   = 4,
  parameter logic [15:0] TIMEOUT = 16'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [DLY_W-1:0] cmd_delay,
  output logic             cmd_ready,
  output logic             ser_data,
  input  logic             done,
  output logic             ack,
  output logic             busy,
  output logic             timeout_err
);

  localparam int MAX_BITS = (DLY_W > 4) ? DLY_W : 4;
  localparam int CNT_W    = $clog2(MAX_BITS);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_W - 1);

  // ST_ACK is the single closing cycle of every command; it carries either
  // the ack pulse or the timeout_err pulse, so cmd_ready returns one cycle
  // after either pulse.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DLY,
    ST_WAIT_DONE,
    ST_ACK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DLY_W-1:0]   shift_q, shift_d;
  logic [15:0]        wd_q, wd_d;
  logic [15:0]        wd_inc;
  logic               ser_data_q, ser_data_d;
  logic               ack_q, ack_d;
  logic               timeout_err_q, timeout_err_d;

  assign cmd_ready   = (state_q == ST_IDLE) && !reset;
  assign busy        = (state_q != ST_IDLE);
  assign ser_data    = ser_data_q;
  assign ack         = ack_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    wd_d          = wd_q;
    ack_d         = 1'b0;
    timeout_err_d = 1'b0;
    ser_data_d    = 1'b0;
    // Saturating increment: the watchdog counter never wraps.
    wd_inc        = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = ST_HDR;
          cnt_d   = '0;
          shift_d = cmd_delay;
        end
      end
      ST_HDR: begin
        if (cnt_q == HDR_LAST) begin
          state_d = ST_DLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DLY: begin
        if (cnt_q == DLY_LAST) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
          wd_d    = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = shift_q << 1;
        end
      end
      ST_WAIT_DONE: begin
        wd_d = wd_inc;
        // done wins over the watchdog when both fire on the same cycle.
        if (done) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else if ((TIMEOUT != 16'd0) && (wd_inc == TIMEOUT)) begin
          state_d       = ST_ACK;
          timeout_err_d = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // ser_data is registered, so it is computed from the state/counter the
    // block is about to enter; this puts HDR[3] on the line the cycle after
    // the handshake.
    case (state_d)
      ST_HDR:  ser_data_d = HDR[2'd3 - cnt_d[1:0]];
      ST_DLY:  ser_data_d = shift_d[DLY_W-1];
      default: ser_data_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      wd_q          <= '0;
      ser_data_q    <= 1'b0;
      ack_q         <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      wd_q          <= wd_d;
      ser_data_q    <= ser_data_d;
      ack_q         <= ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_timer_cmd_tx.sv
// Testbench for timer_cmd_tx. Two instances: u_dut0 with the watchdog
// disabled, u_dut1 with TIMEOUT=8. Stimulus pushes expected frames, acks
// and timeout pulses (with the cycle they must appear in) onto one queue;
// the monitor pops and compares whenever an instance produces one.
module tb_timer_cmd_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [3:0] cmd_delay = 4'b0000;
  logic       cmd_valid0 = 1'b0, done0 = 1'b0;
  logic       cmd_valid1 = 1'b0, done1 = 1'b0;
  logic       cmd_ready0, ser0, ack0, busy0, terr0;
  logic       cmd_ready1, ser1, ack1, busy1, terr1;

  timer_cmd_tx u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid0), .cmd_delay(cmd_delay),
    .cmd_ready(cmd_ready0), .ser_data(ser0), .done(done0), .ack(ack0),
    .busy(busy0), .timeout_err(terr0)
  );

  timer_cmd_tx #(.TIMEOUT(16'd8)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_delay(cmd_delay),
    .cmd_ready(cmd_ready1), .ser_data(ser1), .done(done1), .ack(ack1),
    .busy(busy1), .timeout_err(terr1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  localparam int K_FRAME = 0;
  localparam int K_ACK   = 1;
  localparam int K_TERR  = 2;

  typedef struct {
    int         inst;
    int         kind;
    logic [8:0] val;
    int         at;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ev(input int inst, input int kind, input logic [8:0] val, input int at);
    ev_t e;
    e.inst = inst;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input int inst, input int kind, input logic [8:0] val, input int at, input string name);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s unexpected: dut%0d kind %0d val %b at cyc %0d, nothing expected",
               name, inst, kind, val, at);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.kind != kind || e.val !== val || e.at != at) begin
        n_err++;
        $display("FAIL %s: got dut%0d kind %0d val %b cyc %0d, expected dut%0d kind %0d val %b cyc %0d",
                 name, inst, kind, val, at, e.inst, e.kind, e.val, e.at);
      end
    end
  endtask

  // Monitor
  logic [1:0] m_busy, m_ser, m_ack, m_terr;
  assign m_busy = {busy1, busy0};
  assign m_ser  = {ser1, ser0};
  assign m_ack  = {ack1, ack0};
  assign m_terr = {terr1, terr0};

  int         cap_n[2];
  logic [8:0] cap_bits[2];
  int         cap_at[2];
  logic       busy_prev[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        cap_n[i]     = 0;
        busy_prev[i] = 1'b0;
      end else begin
        if (m_ack[i])  pop_chk(i, K_ACK, 9'd0, cyc, "ack");
        if (m_terr[i]) pop_chk(i, K_TERR, 9'd0, cyc, "timeout_err");
        if (cap_n[i] == 0 && m_busy[i] && !busy_prev[i]) begin
          cap_n[i]    = 1;
          cap_bits[i] = {8'd0, m_ser[i]};
          cap_at[i]   = cyc;
        end else if (cap_n[i] > 0) begin
          cap_bits[i] = {cap_bits[i][7:0], m_ser[i]};
          cap_n[i]    = cap_n[i] + 1;
          if (cap_n[i] == 9) begin
            pop_chk(i, K_FRAME, cap_bits[i], cap_at[i], "frame");
            cap_n[i] = 0;
          end
        end
        if (!m_busy[i]) chk("idle_ser_data", int'(m_ser[i]), 0);
        busy_prev[i] = m_busy[i];
      end
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic send(input int inst, input logic [3:0] d, input logic [8:0] frame, output int t);
    cmd_delay = d;
    if (inst == 0) cmd_valid0 = 1'b1;
    else cmd_valid1 = 1'b1;
    #1;
    chk("cmd_ready_at_handshake", int'(inst == 0 ? cmd_ready0 : cmd_ready1), 1);
    t = cyc;
    expect_ev(inst, K_FRAME, frame, t + 1);
    tick();
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, t2, d;

    // Reset state
    tick(); tick(); tick();
    chk("reset_cmd_ready0", int'(cmd_ready0), 0);
    chk("reset_cmd_ready1", int'(cmd_ready1), 0);
    chk("reset_busy0", int'(busy0), 0);
    chk("reset_ser0", int'(ser0), 0);
    chk("reset_ack0", int'(ack0), 0);
    chk("reset_terr0", int'(terr0), 0);
    reset = 1'b0;
    #1;
    chk("post_reset_cmd_ready0", int'(cmd_ready0), 1);

    // A: delay 0110, done 20 cycles into WAIT_DONE, held high afterwards
    send(0, 4'b0110, 9'b1101_0110_0, t);
    chk("busy_after_handshake", int'(busy0), 1);
    wait_cyc(t + 28);
    done0 = 1'b1;
    expect_ev(0, K_ACK, 9'd0, t + 29);
    tick();
    tick();
    chk("cmd_ready_after_ack", int'(cmd_ready0), 1);
    wait_cyc(t + 36);
    done0 = 1'b0;
    tick();

    // B: delay 1111, done pulses during HDR and DLY are ignored
    send(0, 4'b1111, 9'b1101_1111_0, t);
    wait_cyc(t + 2); done0 = 1'b1; tick(); done0 = 1'b0;
    wait_cyc(t + 6); done0 = 1'b1; tick(); done0 = 1'b0;
    wait_cyc(t + 12);
    chk("still_waiting_busy", int'(busy0), 1);
    chk("still_waiting_ready", int'(cmd_ready0), 0);
    wait_cyc(t + 14);
    done0 = 1'b1;
    expect_ev(0, K_ACK, 9'd0, t + 15);
    tick();
    done0 = 1'b0;
    tick(); tick();

    // C: reset on the 3rd header bit, then a clean 0001 command
    cmd_delay = 4'b1010;
    cmd_valid0 = 1'b1;
    t = cyc;
    tick();
    cmd_valid0 = 1'b0;
    wait_cyc(t + 3);
    reset = 1'b1;
    tick();
    chk("midreset_ser0", int'(ser0), 0);
    chk("midreset_busy0", int'(busy0), 0);
    chk("midreset_cmd_ready0", int'(cmd_ready0), 0);
    chk("midreset_ack0", int'(ack0), 0);
    reset = 1'b0;
    #1;
    chk("after_midreset_cmd_ready0", int'(cmd_ready0), 1);
    send(0, 4'b0001, 9'b1101_0001_0, t2);
    wait_cyc(t2 + 11);
    done0 = 1'b1;
    expect_ev(0, K_ACK, 9'd0, t2 + 12);
    tick();
    done0 = 1'b0;
    tick(); tick();

    // D: back-to-back with cmd_valid held high
    cmd_delay = 4'b1000;
    cmd_valid0 = 1'b1;
    #1;
    chk("b2b_first_ready", int'(cmd_ready0), 1);
    t = cyc;
    expect_ev(0, K_FRAME, 9'b1101_1000_0, t + 1);
    tick();
    cmd_delay = 4'b0011;
    chk("b2b_not_ready_in_frame", int'(cmd_ready0), 0);
    wait_cyc(t + 13);
    d = cyc;
    done0 = 1'b1;
    expect_ev(0, K_ACK, 9'd0, d + 1);
    expect_ev(0, K_FRAME, 9'b1101_0011_0, d + 3);
    tick();
    done0 = 1'b0;
    tick();
    chk("b2b_ready_two_after_done", int'(cmd_ready0), 1);
    tick();
    cmd_valid0 = 1'b0;
    t2 = d + 2;
    wait_cyc(t2 + 13);
    done0 = 1'b1;
    expect_ev(0, K_ACK, 9'd0, t2 + 14);
    tick();
    done0 = 1'b0;
    tick(); tick();

    // E: watchdog instance, done never arrives, then done on the 8th cycle
    send(1, 4'b0101, 9'b1101_0101_0, t);
    expect_ev(1, K_TERR, 9'd0, t + 17);
    wait_cyc(t + 17);
    chk("terr_cycle_ready1", int'(cmd_ready1), 0);
    chk("terr_cycle_busy1", int'(busy1), 1);
    tick();
    chk("after_terr_ready1", int'(cmd_ready1), 1);
    send(1, 4'b0101, 9'b1101_0101_0, t2);
    wait_cyc(t2 + 16);
    done1 = 1'b1;
    expect_ev(1, K_ACK, 9'd0, t2 + 17);
    tick();
    done1 = 1'b0;
    wait_cyc(t2 + 30);

    chk("expect_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
